// File: rtl/kgp_mem_pkg.sv
// Shared types and constants for the KGP_RISC data-memory front end.
package kgp_mem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } dmem_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to
// the requester that was not granted last.
module rr_arb2
    import kgp_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_id,
    output logic       gnt_valid
);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_CPU;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else if (req[REQ_DBG]) begin
            gnt_id = REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU and debug/loader accesses onto the single-port data memory:
// grant in IDLE, strobe in ISSUE, capture read data and pulse ready leaving CAPTURE.
module dmem_arbiter
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmem_state_t       state_q, state_d;
    logic              id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              last_grant_q;
    logic              cpu_ready_q, dbg_ready_q;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

    logic gnt_id, gnt_valid;

    rr_arb2 u_arb (
        .req        ({dbg_req, cpu_req}),
        .last_grant (last_grant_q),
        .gnt_id     (gnt_id),
        .gnt_valid  (gnt_valid)
    );

    // Strobes decode straight from state so an asynchronous reset kills them at once.
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = ISSUE;
            ISSUE: begin
                state_d   = CAPTURE;
                mem_read  = ~we_q;
                mem_write = we_q;
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            id_q         <= REQ_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= REQ_DBG;
            cpu_ready_q  <= 1'b0;
            dbg_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;

            if (state_q == IDLE && gnt_valid) begin
                id_q    <= gnt_id;
                we_q    <= (gnt_id == REQ_DBG) ? dbg_we    : cpu_we;
                addr_q  <= (gnt_id == REQ_DBG) ? dbg_addr  : cpu_addr;
                wdata_q <= (gnt_id == REQ_DBG) ? dbg_wdata : cpu_wdata;
            end

            if (state_q == CAPTURE) begin
                last_grant_q <= id_q;
                if (id_q == REQ_CPU) begin
                    cpu_ready_q <= 1'b1;
                    if (!we_q) cpu_rdata_q <= mem_rdata;
                end else begin
                    dbg_ready_q <= 1'b1;
                    if (!we_q) dbg_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ready = cpu_ready_q;
    assign dbg_ready = dbg_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference (grant choice, service age, word-array memory).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [9:0]  cpu_addr, dbg_addr, mem_addr;
    logic [31:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
    logic        cpu_ready, dbg_ready, mem_read, mem_write;
    logic [31:0] cpu_rdata, dbg_rdata;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Stand-in for data_memory: synchronous write, registered read.
    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= ram[mem_addr];
    end

    // Reference state.
    logic [31:0] mem_ref [1024];
    int          age;            // 0 = free, 1 = in strobe cycle, 2 = awaiting capture
    logic        last_g;
    logic        t_id, t_we;
    logic [9:0]  t_addr;
    logic [31:0] t_wdata, t_rd;
    logic [1:0]  exp_ready;
    logic [31:0] exp_rdata [2];

    int n_checks = 0;
    int n_errors = 0;
    int wr_cycles;
    int ready_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        age          = 0;
        last_g       = 1'b1;
        exp_ready    = 2'b00;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic model_edge();
        exp_ready = 2'b00;
        if (age == 1) begin
            if (t_we) mem_ref[t_addr] = t_wdata;
            else      t_rd = mem_ref[t_addr];
            age = 2;
        end else if (age == 2) begin
            exp_ready[t_id] = 1'b1;
            if (!t_we) exp_rdata[t_id] = t_rd;
            last_g = t_id;
            age = 0;
        end else if (cpu_req || dbg_req) begin
            if (cpu_req && dbg_req) t_id = ~last_g;
            else                    t_id = dbg_req;
            t_we    = t_id ? dbg_we    : cpu_we;
            t_addr  = t_id ? dbg_addr  : cpu_addr;
            t_wdata = t_id ? dbg_wdata : cpu_wdata;
            age = 1;
        end
    endtask

    task automatic compare();
        logic iss;
        iss = (age == 1);
        check("mem_read",  32'(mem_read),  32'(iss && !t_we));
        check("mem_write", 32'(mem_write), 32'(iss && t_we));
        check("cpu_ready", 32'(cpu_ready), 32'(exp_ready[0]));
        check("dbg_ready", 32'(dbg_ready), 32'(exp_ready[1]));
        check("cpu_rdata", cpu_rdata, exp_rdata[0]);
        check("dbg_rdata", dbg_rdata, exp_rdata[1]);
        if (iss) begin
            check("mem_addr", 32'(mem_addr), 32'(t_addr));
            if (t_we) check("mem_wdata", mem_wdata, t_wdata);
        end
        if (cpu_ready) ready_log.push_back(0);
        if (dbg_ready) ready_log.push_back(1);
        if (mem_write) wr_cycles++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [9:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [9:0] a, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = '0;
            mem_ref[i] = '0;
        end
        mem_rdata = '0;
        model_reset();
        wr_cycles = 0;

        // Reset held with both requests up.
        reset = 1'b0;
        set_cpu(1'b1, 1'b1, 10'd9, 32'd748);
        set_dbg(1'b1, 1'b1, 10'd3, 32'd111);
        ticks(3);
        check("rst_mem_addr",  32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_wr_cycles", 32'(wr_cycles), 32'd0);
        reset = 1'b1;

        // First contention goes to the CPU: its store of 748 to addr 9.
        ready_log.delete();
        tick();
        check("first_grant_addr", 32'(mem_addr), 32'd9);
        set_cpu(1'b0, 1'b0, 10'd0, 32'd0);
        set_dbg(1'b0, 1'b0, 10'd0, 32'd0);
        ticks(3);
        check("store_wr_cycles", 32'(wr_cycles), 32'd1);
        check("store_ready_cnt", 32'(ready_log.size()), 32'd1);

        // CPU load of addr 9.
        ready_log.delete();
        set_cpu(1'b1, 1'b0, 10'd9, 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 10'd0, 32'd0);
        ticks(3);
        check("load9_rdata", cpu_rdata, 32'd748);
        check("load9_only_cpu", 32'(ready_log.size() == 1 && ready_log[0] == 0), 32'd1);

        // DBG request held for a single cycle: write 543 to addr 5.
        ready_log.delete();
        set_dbg(1'b1, 1'b1, 10'd5, 32'd543);
        tick();
        set_dbg(1'b0, 1'b0, 10'd0, 32'd0);
        ticks(3);
        check("drop_dbg_ready_cnt", 32'(ready_log.size() == 1 && ready_log[0] == 1), 32'd1);

        // Continuous contention: CPU reads addr 0, DBG writes 2 to addr 0.
        ready_log.delete();
        set_cpu(1'b1, 1'b0, 10'd0, 32'd0);
        set_dbg(1'b1, 1'b1, 10'd0, 32'd2);
        ticks(9);
        set_cpu(1'b0, 1'b0, 10'd0, 32'd0);
        set_dbg(1'b0, 1'b0, 10'd0, 32'd0);
        check("cont_ready_cnt", 32'(ready_log.size()), 32'd3);
        if (ready_log.size() == 3) begin
            check("cont_order0", 32'(ready_log[0]), 32'd0);
            check("cont_order1", 32'(ready_log[1]), 32'd1);
            check("cont_order2", 32'(ready_log[2]), 32'd0);
        end
        check("cont_rdata", cpu_rdata, 32'd2);
        ticks(1);

        // CPU read of addr 5 sees the early-dropped DBG write.
        set_cpu(1'b1, 1'b0, 10'd5, 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 10'd0, 32'd0);
        ticks(3);
        check("load5_rdata", cpu_rdata, 32'd543);

        // Back-to-back CPU loads with req never dropped.
        ready_log.delete();
        for (int i = 0; i < 9; i++) begin
            set_cpu(1'b1, 1'b0, 10'($urandom_range(0, 9)), 32'd0);
            tick();
        end
        set_cpu(1'b0, 1'b0, 10'd0, 32'd0);
        check("b2b_ready_cnt", 32'(ready_log.size()), 32'd3);
        ticks(1);

        // Reset asserted while a CPU store is in its strobe cycle.
        ready_log.delete();
        set_cpu(1'b1, 1'b1, 10'd6, 32'd77);
        tick();
        check("abort_pre_write", 32'(mem_write), 32'd1);
        set_cpu(1'b0, 1'b0, 10'd0, 32'd0);
        reset = 1'b0;
        #1;
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_mem_read",  32'(mem_read),  32'd0);
        model_reset();
        ticks(2);
        reset = 1'b1;
        ticks(3);
        check("abort_no_ready", 32'(ready_log.size()), 32'd0);
        set_cpu(1'b1, 1'b0, 10'd9, 32'd0);
        tick();
        set_cpu(1'b0, 1'b0, 10'd0, 32'd0);
        ticks(3);
        check("post_abort_rdata", cpu_rdata, 32'd748);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            set_cpu(1'($urandom_range(0, 9) < 6), 1'($urandom), 10'($urandom_range(0, 7)), $urandom);
            set_dbg(1'($urandom_range(0, 9) < 6), 1'($urandom), 10'($urandom_range(0, 7)), $urandom);
            tick();
        end
        set_cpu(1'b0, 1'b0, 10'd0, 32'd0);
        set_dbg(1'b0, 1'b0, 10'd0, 32'd0);
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
